// File: rtl/udp_rx_app_buffer.sv
// Store-and-forward receive buffer between the UDP-to-app adapter and the application.
// udp_info is packed as {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], data_length[15:0]}.
module udp_rx_app_buffer #(
  parameter int NOC_DATA_W      = 512,
  parameter int NOC_PADBYTES    = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W  = $clog2(NOC_PADBYTES),
  parameter int DATA_FIFO_DEPTH = 64,
  parameter int META_FIFO_DEPTH = 8,
  parameter int UDP_INFO_W      = 112
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fr_udp_dst_meta_val,
  input  logic [UDP_INFO_W-1:0]     fr_udp_dst_meta_info,
  output logic                      dst_fr_udp_meta_rdy,
  input  logic                      fr_udp_dst_data_val,
  input  logic [NOC_DATA_W-1:0]     fr_udp_dst_data,
  input  logic                      fr_udp_dst_data_last,
  input  logic [NOC_PADBYTES_W-1:0] fr_udp_dst_data_padbytes,
  output logic                      dst_fr_udp_data_rdy,
  output logic                      app_rx_meta_val,
  output logic [UDP_INFO_W-1:0]     app_rx_meta_info,
  input  logic                      app_rx_meta_rdy,
  output logic                      app_rx_data_val,
  output logic [NOC_DATA_W-1:0]     app_rx_data,
  output logic                      app_rx_data_last,
  output logic [NOC_PADBYTES_W-1:0] app_rx_data_padbytes,
  input  logic                      app_rx_data_rdy,
  output logic [31:0]               rx_drop_cnt
);

  localparam int DA_W = $clog2(DATA_FIFO_DEPTH);
  localparam int DC_W = DA_W + 1;
  localparam int MA_W = $clog2(META_FIFO_DEPTH);
  localparam int MC_W = MA_W + 1;
  localparam int DE_W = NOC_DATA_W + 1 + NOC_PADBYTES_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_STORE = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic                    active_r;
  logic [UDP_INFO_W-1:0]   pend_meta_r;
  logic [16:0]             need_r, need_s;
  logic                    commit_r;
  logic [DC_W-1:0]         pkt_cnt_r;
  logic [31:0]             drop_cnt_r;

  logic [DE_W-1:0]         d_mem_r [DATA_FIFO_DEPTH];
  logic [DC_W-1:0]         d_wr_r, d_rd_r, d_cnt_s, d_free_s;
  logic                    d_full_s, d_empty_s, d_push_s, d_pop_s;
  logic [DE_W-1:0]         d_head_s;

  logic [UDP_INFO_W-1:0]   m_mem_r [META_FIFO_DEPTH];
  logic [MC_W-1:0]         m_wr_r, m_rd_r, m_cnt_s;
  logic                    m_full_s, m_empty_s, m_pop_s;

  logic                    meta_rdy_s, data_rdy_s, meta_acc_s, data_acc_s;
  logic                    store_last_s, drop_last_s, pop_last_s;

  assign d_cnt_s   = d_wr_r - d_rd_r;
  assign d_free_s  = DC_W'(DATA_FIFO_DEPTH) - d_cnt_s;
  assign d_full_s  = (d_cnt_s == DC_W'(DATA_FIFO_DEPTH));
  assign d_empty_s = (d_cnt_s == {DC_W{1'b0}});
  assign d_head_s  = d_mem_r[d_rd_r[DA_W-1:0]];

  assign m_cnt_s   = m_wr_r - m_rd_r;
  assign m_full_s  = (m_cnt_s == MC_W'(META_FIFO_DEPTH));
  assign m_empty_s = (m_cnt_s == {MC_W{1'b0}});

  assign meta_acc_s   = fr_udp_dst_meta_val & meta_rdy_s;
  assign data_acc_s   = fr_udp_dst_data_val & data_rdy_s;
  assign d_push_s     = data_acc_s & (state_r == ST_STORE);
  assign store_last_s = d_push_s & fr_udp_dst_data_last;
  assign drop_last_s  = data_acc_s & (state_r == ST_DROP) & fr_udp_dst_data_last;
  assign d_pop_s      = app_rx_data_val & app_rx_data_rdy;
  assign pop_last_s   = d_pop_s & d_head_s[NOC_PADBYTES_W];
  assign m_pop_s      = app_rx_meta_val & app_rx_meta_rdy;

  // Flits needed for a packet, ceil(len / bytes-per-flit) with a floor of one.
  always_comb begin
    need_s = ({1'b0, fr_udp_dst_meta_info[15:0]} + 17'(NOC_PADBYTES - 1)) >> NOC_PADBYTES_W;
    if (need_s == 17'd0) begin
      need_s = 17'd1;
    end else begin
      need_s = need_s;
    end
  end

  // Next-state and handshake decode; readies depend only on registered state.
  always_comb begin
    state_s    = state_r;
    meta_rdy_s = 1'b0;
    data_rdy_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        meta_rdy_s = active_r;
        if (meta_acc_s) begin
          state_s = (need_s > 17'(DATA_FIFO_DEPTH)) ? ST_DROP : ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if ((17'(d_free_s) >= need_r) && !m_full_s) begin
          state_s = ST_STORE;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_STORE: begin
        data_rdy_s = ~d_full_s;
        if (data_acc_s && fr_udp_dst_data_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STORE;
        end
      end
      ST_DROP: begin
        data_rdy_s = 1'b1;
        if (data_acc_s && fr_udp_dst_data_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state; active_r keeps both readies low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      active_r <= 1'b1;
    end
  end

  // Pending metadata and its flit requirement; commit_r publishes a packet one cycle after its last flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_meta_r <= {UDP_INFO_W{1'b0}};
      need_r      <= 17'd0;
      commit_r    <= 1'b0;
    end else begin
      if (meta_acc_s) begin
        pend_meta_r <= fr_udp_dst_meta_info;
        need_r      <= need_s;
      end
      commit_r <= store_last_s;
    end
  end

  // Storage arrays; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (d_push_s) begin
      d_mem_r[d_wr_r[DA_W-1:0]] <= {fr_udp_dst_data, fr_udp_dst_data_last, fr_udp_dst_data_padbytes};
    end
    if (commit_r) begin
      m_mem_r[m_wr_r[MA_W-1:0]] <= pend_meta_r;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wr_r <= {DC_W{1'b0}};
      d_rd_r <= {DC_W{1'b0}};
      m_wr_r <= {MC_W{1'b0}};
      m_rd_r <= {MC_W{1'b0}};
    end else begin
      if (d_push_s) d_wr_r <= d_wr_r + DC_W'(1);
      if (d_pop_s)  d_rd_r <= d_rd_r + DC_W'(1);
      if (commit_r) m_wr_r <= m_wr_r + MC_W'(1);
      if (m_pop_s)  m_rd_r <= m_rd_r + MC_W'(1);
    end
  end

  // Completed-packet count gating data release, plus saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_r  <= {DC_W{1'b0}};
      drop_cnt_r <= 32'd0;
    end else begin
      case ({commit_r, pop_last_s})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + DC_W'(1);
        2'b01:   pkt_cnt_r <= pkt_cnt_r - DC_W'(1);
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
      if (drop_last_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end

  assign dst_fr_udp_meta_rdy  = meta_rdy_s;
  assign dst_fr_udp_data_rdy  = data_rdy_s;
  assign app_rx_meta_val      = ~m_empty_s;
  assign app_rx_meta_info     = m_mem_r[m_rd_r[MA_W-1:0]];
  assign app_rx_data_val      = ~d_empty_s & (pkt_cnt_r != {DC_W{1'b0}});
  assign app_rx_data          = d_head_s[DE_W-1 -: NOC_DATA_W];
  assign app_rx_data_last     = d_head_s[NOC_PADBYTES_W];
  assign app_rx_data_padbytes = d_head_s[NOC_PADBYTES_W-1:0];
  assign rx_drop_cnt          = drop_cnt_r;

endmodule
